// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch unit. It owns the architectural PC and fetches one
// instruction at a time over a valid/ready imem port. Each fetched word is presented to
// decode together with its PC. The next PC is written back from execute.
// Optional build macro IFU_PERF_CNT_EN adds 64-bit fetch and stall counters.
module ifu_fetch #(
  parameter int unsigned          ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h80000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISA_WIDTH-1:0] pc_in,
  input  logic                 pc_w_en,
  output logic [ISA_WIDTH-1:0] pc_out,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ISA_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  output logic                 imem_resp_ready,
  input  logic [31:0]          imem_resp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]          perf_fetch_cnt,
  output logic [63:0]          perf_stall_cnt,
`endif
  output logic [31:0]          inst,
  output logic [ISA_WIDTH-1:0] inst_pc
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StExec
  } state_e;

  state_e                 state_q, state_d;
  logic [ISA_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]            inst_q, inst_d;

  // State, PC and instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b0;
    inst_valid      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        imem_resp_ready = 1'b1;
        if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          state_d = StHold;
        end
      end
      StHold: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = StExec;
      end
      StExec: begin
        // Without a PC write the unit hangs here until reset (illegal instruction).
        if (pc_w_en) begin
          pc_d    = pc_in;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The PC only moves in EXEC, so it is also the PC of the held instruction.
  assign pc_out        = pc_q;
  assign imem_req_addr = pc_q;
  assign inst_pc       = pc_q;
  assign inst          = inst_q;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q;
  logic        fetch_evt, stall_evt;

  assign fetch_evt = (state_q == StWait) && imem_resp_valid;
  assign stall_evt = ((state_q == StReq) && !imem_req_ready) ||
                     ((state_q == StWait) && !imem_resp_valid);

  // Free-running performance counters, wrapping on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 64'h0;
      stall_cnt_q <= 64'h0;
    end else begin
      if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (stall_evt) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized stall lengths,
// instruction words and next-PC values checked against a transaction-level model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h80000000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_w_en;
  logic [31:0] pc_out;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ifu_fetch #(
    .ISA_WIDTH (32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_w_en         (pc_w_en),
    .pc_out          (pc_out),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: architectural PC, last captured word, expected counter values.
  logic [31:0] exp_pc;
  logic [31:0] last_inst;
  logic [63:0] exp_fetch;
  logic [63:0] exp_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_perf();
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, exp_fetch);
    check("perf_stall", perf_stall_cnt, exp_stall);
`endif
  endtask

  // Inputs that the DUT must ignore in its current state.
  task automatic noise();
    imem_resp_valid = 1'($urandom_range(0, 1));
    imem_resp_data  = $urandom;
    pc_w_en         = 1'($urandom_range(0, 1));
    pc_in           = $urandom;
  endtask

  task automatic check_idle();
    check("idle_pc", pc_out, RST_PC);
    check("idle_addr", imem_req_addr, RST_PC);
    check("idle_inst_pc", inst_pc, RST_PC);
    check("idle_inst", inst, 32'h0);
    check("idle_req_valid", imem_req_valid, 0);
    check("idle_resp_ready", imem_resp_ready, 0);
    check("idle_inst_valid", inst_valid, 0);
    check_perf();
  endtask

  task automatic check_req();
    check("req_valid", imem_req_valid, 1);
    check("req_addr", imem_req_addr, exp_pc);
    check("req_pc", pc_out, exp_pc);
    check("req_resp_ready", imem_resp_ready, 0);
    check("req_inst_valid", inst_valid, 0);
    check("req_inst_held", inst, last_inst);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    pc_w_en         = 1'b0;
    @(negedge clk);
    exp_pc    = RST_PC;
    last_inst = 32'h0;
    exp_fetch = 64'd0;
    exp_stall = 64'd0;
    check_idle();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One fetch from REQ to EXEC; entered at a negedge with the DUT in REQ.
  task automatic do_fetch(input int rs, input int ws, input int ds, input logic [31:0] word);
    check_req();
    for (int i = 0; i < rs; i++) begin
      imem_req_ready = 1'b0;
      noise();
      @(negedge clk);
      exp_stall++;
      check_req();
    end
    imem_req_ready = 1'b1;
    noise();
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("wait_resp_ready", imem_resp_ready, 1);
    check("wait_req_valid", imem_req_valid, 0);
    for (int i = 0; i < ws; i++) begin
      imem_resp_valid = 1'b0;
      pc_w_en         = 1'b1;
      pc_in           = $urandom;
      @(negedge clk);
      exp_stall++;
      check("wait_pc_kept", pc_out, exp_pc);
      check("wait_resp_ready", imem_resp_ready, 1);
    end
    pc_w_en         = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    @(negedge clk);
    exp_fetch++;
    last_inst = word;
    for (int i = 0; i <= ds; i++) begin
      check("hold_inst_valid", inst_valid, 1);
      check("hold_inst", inst, word);
      check("hold_inst_pc", inst_pc, exp_pc);
      check("hold_req_valid", imem_req_valid, 0);
      check("hold_resp_ready", imem_resp_ready, 0);
      inst_ready = (i == ds);
      noise();
      @(negedge clk);
    end
    inst_ready      = 1'b0;
    imem_resp_valid = 1'b0;
    pc_w_en         = 1'b0;
    check("exec_inst_valid", inst_valid, 0);
    check("exec_req_valid", imem_req_valid, 0);
    check("exec_pc", pc_out, exp_pc);
    check("exec_inst", inst, word);
    check_perf();
  endtask

  task automatic exec_go(input logic [31:0] npc);
    pc_w_en         = 1'b1;
    pc_in           = npc;
    imem_resp_valid = 1'b0;
    @(negedge clk);
    pc_w_en = 1'b0;
    exp_pc  = npc;
  endtask

  initial begin
    rst             = 1'b1;
    pc_in           = 32'h0;
    pc_w_en         = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Sequential fetch with everything ready.
    for (int i = 0; i < 3; i++) begin
      do_fetch(0, 0, 0, 32'h00000013);
      exec_go(exp_pc + 32'd4);
    end
    check("seq_addr", imem_req_addr, 32'h8000000C);

    // Request stall, then decode stall.
    do_fetch(3, 0, 0, 32'hDEADBEEF);
    exec_go(exp_pc + 32'd4);
    do_fetch(0, 0, 5, 32'h12345678);

    // Jump, then PC writes pulsed while waiting for the response.
    exec_go(32'h80000100);
    check("jump_addr", imem_req_addr, 32'h80000100);
    do_fetch(0, 3, 0, 32'hCAFEF00D);

    // Two fetches with 2-cycle response delay from a fresh reset.
    do_reset();
    do_fetch(0, 2, 0, 32'h00000013);
    exec_go(exp_pc + 32'd4);
    do_fetch(0, 2, 0, 32'h00000093);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_two", perf_fetch_cnt, 64'd2);
    check("perf_stall_four", perf_stall_cnt, 64'd4);
`endif

    // Misaligned target taken verbatim, and wrap past the top of the address space.
    exec_go(32'h80000102);
    do_fetch(1, 1, 1, $urandom);
    exec_go(32'hFFFFFFFC);
    do_fetch(0, 0, 0, $urandom);
    exec_go(exp_pc + 32'd4);
    check("wrap_addr", imem_req_addr, 32'h0);

    // Randomized fetch stream.
    for (int n = 0; n < 25; n++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) exec_go(exp_pc + 32'd4);
      else exec_go($urandom);
    end

    // Hang in EXEC without a PC write; only reset recovers.
    do_fetch(0, 0, 0, 32'h0000FFFF);
    for (int i = 0; i < 20; i++) begin
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data  = $urandom;
      @(negedge clk);
      check("hang_req_valid", imem_req_valid, 0);
      check("hang_pc", pc_out, exp_pc);
      check("hang_inst_valid", inst_valid, 0);
    end
    do_reset();
    do_fetch(0, 0, 0, 32'h00000013);
    exec_go(exp_pc + 32'd4);

    // Reset while waiting for a response drops the fetch.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("mid_resp_ready", imem_resp_ready, 1);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBADBAD00;
    rst             = 1'b1;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    exp_pc    = RST_PC;
    last_inst = 32'h0;
    exp_fetch = 64'd0;
    exp_stall = 64'd0;
    check_idle();
    rst = 1'b0;
    @(negedge clk);
    do_fetch(0, 1, 0, 32'h00100073);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
